// File: rtl/rx_word_packer.sv
// 8N1 serial receiver that packs four consecutive bytes (first byte -> [7:0]) into a 32-bit word.
// Optional inter-byte gap timeout enabled by defining RX_TIMEOUT_EN.
module rx_word_packer #(
  parameter int CLKS_PER_BIT = 42,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic [31:0] data_out,
  output logic        rx_done,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("rx_word_packer: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [31:0]   word;
  logic [1:0]    byte_cnt;
  logic          fall, bit_end, half_end;
  logic          cnt_clr, shift_en, stop_ok, stop_bad, tmo;

  assign fall     = rx_prev & ~rx_s;
  assign bit_end  = (bit_cnt == BIT_LAST);
  assign half_end = (bit_cnt == BIT_HALF);
  assign busy     = (state != S_IDLE) || (byte_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_n = S_START;
          cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (half_end) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            cnt_clr = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_n  = S_IDLE;
          stop_ok  = rx_s;
          stop_bad = ~rx_s;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      word      <= '0;
      byte_cnt  <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx_in;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      rx_done   <= 1'b0;
      frame_err <= stop_bad;

      if (cnt_clr || bit_end) bit_cnt <= '0;
      else                    bit_cnt <= bit_cnt + 1'b1;

      if (cnt_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;

      if (shift_en) shreg <= {rx_s, shreg[7:1]};

      if (stop_ok) begin
        word[{byte_cnt, 3'b000} +: 8] <= shreg;
        if (byte_cnt == 2'd3) begin
          // byte 3 bypasses word so data_out and rx_done land together
          data_out <= {shreg, word[23:0]};
          rx_done  <= 1'b1;
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (stop_bad || tmo) begin
        byte_cnt <= '0;
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int GAP_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW      = $clog2(GAP_MAX + 1);

  logic [GW-1:0] gap_cnt;

  assign tmo = (state == S_IDLE) && (byte_cnt != 2'd0) && (gap_cnt == GW'(GAP_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo;
      if (state != S_IDLE || byte_cnt == 2'd0 || fall || tmo) gap_cnt <= '0;
      else                                                   gap_cnt <= gap_cnt + 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
